// File: rtl/nrx_vram_arb.sv
`timescale 1ns/1ps
// rtl/nrx_vram_arb.sv - single-port VRAM arbiter between video fetcher and Z80, video priority with CPU starvation bound
module nrx_vram_arb #(
    parameter int CPU_MAXWAIT = 6,
    parameter int AW = 12
) (
    input  logic          CLK24M,
    input  logic          RESET_n,
    input  logic          VREQ,
    input  logic [AW-1:0] VADDR,
    output logic          VACK,
    output logic [7:0]    VDATA,
    output logic          VOVR,
    input  logic          CREQ,
    input  logic          CWE,
    input  logic [AW-1:0] CADDR,
    input  logic [7:0]    CDI,
    output logic [7:0]    CDO,
    output logic          CACK,
    output logic          WAIT_n,
    output logic [AW-1:0] RAD,
    output logic          RWE,
    output logic [7:0]    RDI,
    input  logic [7:0]    RDO
);
    localparam int CW = $clog2(CPU_MAXWAIT + 2);
    localparam logic [CW-1:0] CMAX = CW'(CPU_MAXWAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_ACC,
        ST_V_DAT,
        ST_C_ACC,
        ST_C_DAT,
        ST_ACK
    } state_t;

    state_t        state;
    logic          vpend;
    logic          cdone;
    logic [AW-1:0] vaddr_q;
    logic [CW-1:0] cwait;
    logic          c_elig;
    logic          c_over;
    logic          grant_c;
    logic          grant_v;

    // A CREQ still held after its CACK is not eligible until it has been seen low.
    always_comb begin
        c_elig  = CREQ & ~cdone;
        c_over  = c_elig & (cwait >= CMAX);
        grant_c = (state == ST_IDLE) & (c_over | (c_elig & ~vpend));
        grant_v = (state == ST_IDLE) & vpend & ~c_over;
    end

    assign WAIT_n = ~c_elig;

    always_ff @(posedge CLK24M or negedge RESET_n) begin
        if (!RESET_n) begin
            state   <= ST_IDLE;
            vpend   <= 1'b0;
            cdone   <= 1'b0;
            cwait   <= '0;
            vaddr_q <= '0;
            VOVR    <= 1'b0;
            VACK    <= 1'b0;
            CACK    <= 1'b0;
            RWE     <= 1'b0;
            RAD     <= '0;
            RDI     <= 8'h00;
            VDATA   <= 8'h00;
            CDO     <= 8'h00;
        end else begin
            VACK <= 1'b0;
            CACK <= 1'b0;
            RWE  <= 1'b0;

            // A request landing on the grant edge becomes the next pending one.
            if (VREQ) begin
                if (vpend && !grant_v) begin
                    VOVR <= 1'b1;
                end else begin
                    vpend   <= 1'b1;
                    vaddr_q <= VADDR;
                end
            end else if (grant_v) begin
                vpend <= 1'b0;
            end

            if (!CREQ) begin
                cdone <= 1'b0;
            end

            if (grant_c) begin
                cwait <= '0;
            end else if (c_elig && (cwait < CMAX)) begin
                cwait <= cwait + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_c) begin
                        state <= ST_C_ACC;
                        RAD   <= CADDR;
                        RWE   <= CWE;
                        if (CWE) begin
                            RDI <= CDI;
                        end
                    end else if (grant_v) begin
                        state <= ST_V_ACC;
                        RAD   <= vaddr_q;
                    end
                end
                ST_V_ACC: state <= ST_V_DAT;
                ST_V_DAT: begin
                    VDATA <= RDO;
                    VACK  <= 1'b1;
                    state <= ST_ACK;
                end
                // RWE is only ever high here for a write, so it doubles as the access type.
                ST_C_ACC: begin
                    if (RWE) begin
                        CACK  <= 1'b1;
                        cdone <= 1'b1;
                        state <= ST_ACK;
                    end else begin
                        state <= ST_C_DAT;
                    end
                end
                ST_C_DAT: begin
                    CDO   <= RDO;
                    CACK  <= 1'b1;
                    cdone <= 1'b1;
                    state <= ST_ACK;
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nrx_vram_arb.sv
`timescale 1ns/1ps
// tb/tb_nrx_vram_arb.sv - self-checking bench for nrx_vram_arb with synchronous RAM and memory reference model
module tb_nrx_vram_arb;
    localparam int CPU_MAXWAIT = 6;
    localparam int AW = 12;

    logic          CLK24M = 1'b0;
    logic          RESET_n = 1'b0;
    logic          VREQ = 1'b0;
    logic [AW-1:0] VADDR = '0;
    logic          VACK;
    logic [7:0]    VDATA;
    logic          VOVR;
    logic          CREQ = 1'b0;
    logic          CWE = 1'b0;
    logic [AW-1:0] CADDR = '0;
    logic [7:0]    CDI = 8'h00;
    logic [7:0]    CDO;
    logic          CACK;
    logic          WAIT_n;
    logic [AW-1:0] RAD;
    logic          RWE;
    logic [7:0]    RDI;
    logic [7:0]    RDO = 8'h00;

    logic [7:0] ram   [0:4095];
    logic [7:0] model [0:4095];

    int n_checks = 0;
    int n_fail = 0;

    nrx_vram_arb #(.CPU_MAXWAIT(CPU_MAXWAIT), .AW(AW)) dut (
        .CLK24M(CLK24M), .RESET_n(RESET_n),
        .VREQ(VREQ), .VADDR(VADDR), .VACK(VACK), .VDATA(VDATA), .VOVR(VOVR),
        .CREQ(CREQ), .CWE(CWE), .CADDR(CADDR), .CDI(CDI), .CDO(CDO),
        .CACK(CACK), .WAIT_n(WAIT_n),
        .RAD(RAD), .RWE(RWE), .RDI(RDI), .RDO(RDO)
    );

    always #20 CLK24M = ~CLK24M;

    always @(posedge CLK24M) begin
        if (RWE) ram[RAD] <= RDI;
        RDO <= ram[RAD];
    end

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    task automatic step;
        @(posedge CLK24M);
        #1;
    endtask

    task automatic do_reset;
        VREQ = 1'b0; CREQ = 1'b0; CWE = 1'b0;
        RESET_n = 1'b0;
        repeat (2) step;
        RESET_n = 1'b1;
        step;
    endtask

    task automatic test_reset;
        VREQ = 1'b0; CREQ = 1'b0;
        RESET_n = 1'b0;
        repeat (2) step;
        n_checks++;
        if ({VACK, VOVR, CACK, RWE} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000", {VACK, VOVR, CACK, RWE});
        end
        n_checks++;
        if ({VDATA, CDO, RDI} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=000000", {VDATA, CDO, RDI});
        end
        n_checks++;
        if (RAD !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_rad got=%h exp=000", RAD);
        end
        n_checks++;
        if (WAIT_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_idle got=%b exp=1", WAIT_n);
        end
        CREQ = 1'b1;
        #1;
        n_checks++;
        if (WAIT_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_follows_creq got=%b exp=0", WAIT_n);
        end
        CREQ = 1'b0;
        RESET_n = 1'b1;
        step;
    endtask

    task automatic test_video_read;
        logic [7:0] vd_hold;
        do_reset;
        ram[12'h123] = 8'hA5; model[12'h123] = 8'hA5;
        VADDR = 12'h123; VREQ = 1'b1;
        step;
        VREQ = 1'b0; VADDR = 12'($urandom);
        step;
        n_checks++;
        if ({RAD, RWE, VACK} !== {12'h123, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL vid_e1 got rad=%h rwe=%b vack=%b exp rad=123 rwe=0 vack=0", RAD, RWE, VACK);
        end
        step;
        n_checks++;
        if (VACK !== 1'b0) begin
            n_fail++;
            $display("FAIL vid_e2_vack got=%b exp=0", VACK);
        end
        step;
        n_checks++;
        if ({VACK, VDATA} !== {1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL vid_e3 got vack=%b vdata=%h exp vack=1 vdata=a5", VACK, VDATA);
        end
        vd_hold = VDATA;
        step;
        n_checks++;
        if ({VACK, VDATA} !== {1'b0, 8'hA5}) begin
            n_fail++;
            $display("FAIL vid_hold got vack=%b vdata=%h exp vack=0 vdata=a5", VACK, VDATA);
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 5;
        logic [11:0] addr [N];
        int bad = 0;
        int k;
        do_reset;
        for (int i = 0; i < N; i++) addr[i] = 12'h800 | 12'($urandom_range(0, 2047));
        for (int c = 0; c < 4 * N + 2; c++) begin
            VREQ = (c % 4 == 0) && (c < 4 * N);
            if (VREQ) VADDR = addr[c / 4];
            step;
            k = (c - 3) / 4;
            if (c >= 3 && (c - 3) % 4 == 0 && k < N) begin
                if (VACK !== 1'b1 || VDATA !== model[addr[k]]) bad++;
            end else if (VACK !== 1'b0) begin
                bad++;
            end
        end
        VREQ = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_throughput got=%0d bad cycles exp=0", bad);
        end
    endtask

    task automatic test_cpu_write_read;
        int rwe_cnt, cack_cnt, cack_at, bad_wait, bad_rwe;
        do_reset;
        CREQ = 1'b1; CWE = 1'b1; CADDR = 12'h7FF; CDI = 8'h3C;
        #1;
        n_checks++;
        if (WAIT_n !== 1'b0) begin
            n_fail++;
            $display("FAIL cw_wait_low got=%b exp=0", WAIT_n);
        end
        rwe_cnt = 0; cack_cnt = 0; cack_at = -1; bad_wait = 0; bad_rwe = 0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (RWE) begin
                rwe_cnt++;
                if (RDI !== 8'h3C || RAD !== 12'h7FF) bad_rwe++;
            end
            if (CACK) begin cack_cnt++; cack_at = i; end
            if (WAIT_n !== (cack_cnt > 0)) bad_wait++;
        end
        model[12'h7FF] = 8'h3C;
        n_checks++;
        if (rwe_cnt != 1 || bad_rwe != 0) begin
            n_fail++;
            $display("FAIL cw_rwe_pulse got=%0d pulses %0d bad exp=1 pulse 0 bad", rwe_cnt, bad_rwe);
        end
        n_checks++;
        if (cack_cnt != 1 || cack_at != 1) begin
            n_fail++;
            $display("FAIL cw_cack got=%0d acks at %0d exp=1 at 1", cack_cnt, cack_at);
        end
        n_checks++;
        if (bad_wait != 0) begin
            n_fail++;
            $display("FAIL cw_wait_n got=%0d bad cycles exp=0", bad_wait);
        end
        CREQ = 1'b0;
        step;
        CREQ = 1'b1; CWE = 1'b0; CDI = 8'h00;
        cack_cnt = 0; cack_at = -1; bad_wait = 0; rwe_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (RWE) rwe_cnt++;
            if (CACK) begin cack_cnt++; cack_at = i; end
            if (WAIT_n !== (cack_cnt > 0)) bad_wait++;
        end
        n_checks++;
        if (cack_cnt != 1 || cack_at != 2 || rwe_cnt != 0) begin
            n_fail++;
            $display("FAIL cr_cack got=%0d acks at %0d rwe=%0d exp=1 at 2 rwe=0", cack_cnt, cack_at, rwe_cnt);
        end
        n_checks++;
        if (CDO !== model[12'h7FF]) begin
            n_fail++;
            $display("FAIL cr_cdo got=%h exp=%h", CDO, model[12'h7FF]);
        end
        n_checks++;
        if (bad_wait != 0) begin
            n_fail++;
            $display("FAIL cr_wait_n got=%0d bad cycles exp=0", bad_wait);
        end
        CREQ = 1'b0;
        step;
    endtask

    task automatic test_starvation;
        logic [11:0] vq[$];
        int since, lat, vacks_after, vbad;
        logic cack_seen;
        do_reset;
        since = 4; lat = 0; vacks_after = 0; vbad = 0; cack_seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            VREQ = 1'b0;
            if (vq.size() == 0 && since >= 4) begin
                VREQ = 1'b1;
                VADDR = 12'h800 | 12'($urandom_range(0, 2047));
                vq.push_back(VADDR);
                since = 0;
            end
            if (c == 12) begin CREQ = 1'b1; CWE = 1'b0; CADDR = 12'h050; end
            step;
            since++;
            if (VACK) begin
                if (vq.size() == 0) vbad++;
                else begin
                    if (VDATA !== model[vq[0]]) vbad++;
                    void'(vq.pop_front());
                end
                if (cack_seen) vacks_after++;
            end
            if (CREQ && !cack_seen) begin
                lat++;
                if (CACK) begin
                    cack_seen = 1'b1;
                    CREQ = 1'b0;
                    n_checks++;
                    if (CDO !== model[12'h050]) begin
                        n_fail++;
                        $display("FAIL starve_cdo got=%h exp=%h", CDO, model[12'h050]);
                    end
                end
            end
        end
        VREQ = 1'b0; CREQ = 1'b0;
        n_checks++;
        if (!cack_seen || lat < CPU_MAXWAIT + 3 || lat > CPU_MAXWAIT + 6) begin
            n_fail++;
            $display("FAIL starve_latency got=%0d seen=%b exp=%0d..%0d", lat, cack_seen, CPU_MAXWAIT + 3, CPU_MAXWAIT + 6);
        end
        n_checks++;
        if (vacks_after < 2 || vbad != 0) begin
            n_fail++;
            $display("FAIL starve_video got=%0d after %0d bad exp>=2 after 0 bad", vacks_after, vbad);
        end
        n_checks++;
        if (VOVR !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_vovr got=%b exp=0", VOVR);
        end
    endtask

    task automatic test_overrun;
        logic [11:0] a, b;
        int vack_cnt, cack_cnt;
        logic [7:0] vd;
        logic saw_b;
        do_reset;
        a = 12'h9AB; b = 12'hC34;
        vack_cnt = 0; cack_cnt = 0; vd = 8'h00; saw_b = 1'b0;
        CREQ = 1'b1; CWE = 1'b0; CADDR = 12'h111;
        for (int i = 0; i < 20; i++) begin
            VREQ = (i == 1) || (i == 2);
            VADDR = (i == 1) ? a : b;
            step;
            if (CACK) begin cack_cnt++; CREQ = 1'b0; end
            if (VACK) begin vack_cnt++; vd = VDATA; end
            if (RAD == b) saw_b = 1'b1;
        end
        VREQ = 1'b0;
        n_checks++;
        if (VOVR !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_vovr got=%b exp=1", VOVR);
        end
        n_checks++;
        if (vack_cnt != 1 || vd !== model[a] || saw_b) begin
            n_fail++;
            $display("FAIL ovr_first_only got=%0d acks data=%h sawb=%b exp=1 acks data=%h sawb=0", vack_cnt, vd, saw_b, model[a]);
        end
        n_checks++;
        if (cack_cnt != 1) begin
            n_fail++;
            $display("FAIL ovr_cpu_cack got=%0d exp=1", cack_cnt);
        end
    endtask

    task automatic test_reset_mid_access;
        int acks, lat;
        do_reset;
        CREQ = 1'b1; CWE = 1'b0; CADDR = 12'h2A0;
        step;
        step;
        RESET_n = 1'b0;
        #1;
        acks = 0;
        n_checks++;
        if ({CACK, RAD, WAIT_n} !== {1'b0, 12'h000, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_async got cack=%b rad=%h wait=%b exp cack=0 rad=000 wait=0", CACK, RAD, WAIT_n);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            if (CACK) acks++;
        end
        RESET_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 10 && acks == 0; i++) begin
            step;
            lat++;
            if (CACK) acks++;
        end
        n_checks++;
        if (acks != 1 || lat != 3) begin
            n_fail++;
            $display("FAIL rst_mid_reserve got=%0d acks lat=%0d exp=1 acks lat=3", acks, lat);
        end
        n_checks++;
        if (CDO !== model[12'h2A0]) begin
            n_fail++;
            $display("FAIL rst_mid_cdo got=%h exp=%h", CDO, model[12'h2A0]);
        end
        CREQ = 1'b0;
        step;
    endtask

    task automatic test_random;
        logic [11:0] vq[$];
        int cpu_phase, cpu_lat, hold, vlat;
        int e_vid, e_cpu, e_rwe, e_wait, e_ovr, n_vid, n_cpu;
        do_reset;
        cpu_phase = 0; cpu_lat = 0; hold = 0; vlat = 0;
        e_vid = 0; e_cpu = 0; e_rwe = 0; e_wait = 0; e_ovr = 0; n_vid = 0; n_cpu = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (cpu_phase == 3) begin
                cpu_phase = 0;
            end else if (cpu_phase == 0 && $urandom_range(0, 3) == 0) begin
                CREQ = 1'b1; CWE = 1'($urandom);
                CADDR = 12'($urandom_range(0, 12'h7FF)); CDI = 8'($urandom);
                cpu_phase = 1; cpu_lat = 0;
            end
            VREQ = 1'b0;
            if (vq.size() == 0 && $urandom_range(0, 2) == 0) begin
                VREQ = 1'b1;
                VADDR = 12'h800 | 12'($urandom_range(0, 2047));
                vq.push_back(VADDR);
                vlat = 0;
            end
            step;
            if (VACK) begin
                n_vid++;
                if (vq.size() == 0) e_vid++;
                else begin
                    if (VDATA !== model[vq[0]]) e_vid++;
                    void'(vq.pop_front());
                end
            end else if (vq.size() != 0) begin
                vlat++;
                if (vlat > 12) begin e_vid++; vq.delete(); end
            end
            if (RWE && !(cpu_phase == 1 && CWE && RAD == CADDR && RDI == CDI)) e_rwe++;
            if (CACK) begin
                n_cpu++;
                if (cpu_phase != 1) e_cpu++;
                else begin
                    if (!CWE && CDO !== model[CADDR]) e_cpu++;
                    if (CWE) model[CADDR] = CDI;
                    cpu_phase = 2;
                    hold = $urandom_range(0, 2);
                end
            end else if (cpu_phase == 1) begin
                cpu_lat++;
                if (cpu_lat > CPU_MAXWAIT + 7) begin e_cpu++; CREQ = 1'b0; cpu_phase = 3; end
            end
            if (WAIT_n !== (cpu_phase != 1)) e_wait++;
            if (VOVR !== 1'b0) e_ovr++;
            if (cpu_phase == 2) begin
                if (hold == 0) begin CREQ = 1'b0; cpu_phase = 3; end
                else hold--;
            end
        end
        VREQ = 1'b0; CREQ = 1'b0;
        repeat (12) step;
        n_checks++;
        if (e_vid != 0 || n_vid < 100) begin
            n_fail++;
            $display("FAIL rnd_video got=%0d errors %0d reads exp=0 errors >=100 reads", e_vid, n_vid);
        end
        n_checks++;
        if (e_cpu != 0 || n_cpu < 100) begin
            n_fail++;
            $display("FAIL rnd_cpu got=%0d errors %0d accesses exp=0 errors >=100 accesses", e_cpu, n_cpu);
        end
        n_checks++;
        if (e_rwe != 0) begin
            n_fail++;
            $display("FAIL rnd_rwe got=%0d stray writes exp=0", e_rwe);
        end
        n_checks++;
        if (e_wait != 0) begin
            n_fail++;
            $display("FAIL rnd_wait_n got=%0d bad cycles exp=0", e_wait);
        end
        n_checks++;
        if (e_ovr != 0) begin
            n_fail++;
            $display("FAIL rnd_vovr got=%0d cycles set exp=0", e_ovr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = pat(i);
            model[i] = pat(i);
        end
        test_reset;
        test_video_read;
        test_back_to_back;
        test_cpu_write_read;
        test_starvation;
        test_overrun;
        test_reset_mid_access;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nrx_vram_arb.md
# nrx_vram_arb

Single-port video-RAM arbiter for the New Rally-X core. It sits between the Z80 memory path and the video tile/sprite fetcher and shares one synchronous 4 KB VRAM between them. Video fetches get priority. A starvation counter bounds CPU latency, and the CPU is stalled through WAIT_n until its access completes. All logic runs on the 24.576 MHz system clock.

## Interface
- `CPU_MAXWAIT`, default 6: CPU-pending cycles after which the CPU wins arbitration over a pending video request.
- `AW`, default 12: VRAM address width.

Ports:
- `CLK24M`  in  1  system clock, 24.576 MHz; the only clock.
- `RESET_n`  in  1  reset, asynchronous, active-low.
- `VREQ`  in  1  video fetch request, single-cycle pulse.
- `VADDR`  in  AW  video address, sampled with VREQ.
- `VACK`  out  1  one-cycle pulse: VDATA valid.
- `VDATA`  out  8  video read data, held until next video read.
- `VOVR`  out  1  sticky: VREQ arrived while a video request was still pending; cleared only by reset.
- `CREQ`  in  1  CPU access request, level; held until CACK.
- `CWE`  in  1  CPU write (1) / read (0), stable while CREQ.
- `CADDR`  in  AW  CPU address, stable while CREQ.
- `CDI`  in  8  CPU write data.
- `CDO`  out  8  CPU read data, held until next CPU read.
- `CACK`  out  1  one-cycle pulse: CPU access complete.
- `WAIT_n`  out  1  Z80 wait, low while CREQ high and not yet acknowledged.
- `RAD`  out  AW  RAM address, registered.
- `RWE`  out  1  RAM write enable, registered.
- `RDI`  out  8  RAM write data, registered.
- `RDO`  in  8  RAM read data; synchronous RAM, valid one cycle after address.

## Operation
- `vpend`:
  - set on VREQ;
  - `vaddr_q` latched from VADDR at the same edge;
  - cleared when video is granted.
  - VREQ while vpend=1 and not granted that same edge sets VOVR and is dropped; `vaddr_q` keeps the older address.
  - VREQ on the grant edge is accepted as a new pending request.
- `cdone`:
  - set with CACK;
  - cleared when CREQ is sampled low.
  - CPU is eligible only when CREQ=1 and cdone=0, so a CREQ still held after CACK is not re-served.
- WAIT_n is combinational: ~(CREQ & ~cdone).
- `cwait`: saturating counter of cycles the CPU is eligible but not granted; reset to 0 on CPU grant.
- FSM states: IDLE, V_ACC, V_DAT, C_ACC, C_DAT, ACK.
- IDLE arbitration, in priority order:
  1. CPU eligible and cwait ≥ CPU_MAXWAIT → CPU;
  2. vpend → video;
  3. CPU eligible → CPU;
  4. otherwise stay in IDLE.
- Video grant → V_ACC: RAD=vaddr_q, RWE=0. Then V_DAT. Then ACK: VDATA←RDO, VACK=1.
- CPU read → C_ACC: RAD=CADDR, RWE=0. Then C_DAT. Then ACK: CDO←RDO, CACK=1, cdone←1.
- CPU write → C_ACC: RAD=CADDR, RWE=1, RDI=CDI. Then ACK: CACK=1, cdone←1.
- ACK always returns to IDLE. RWE is 1 only in C_ACC for a write.
- Reset: state=IDLE; vpend, cdone, cwait, VOVR, VACK, CACK, RWE=0; RAD, RDI, VDATA, CDO=0. WAIT_n follows CREQ during reset.
- Reset mid-access: the access is abandoned and no ACK is issued. A CPU still holding CREQ is re-served after reset.

## Timing
- Video read: VREQ sampled at edge E0; IDLE grants at E1; RDO valid after E2; VACK high during the cycle after E3, 3 edges after request. Only when the FSM is IDLE at E0 and no CPU override applies.
- CPU read granted at edge G: CACK high in cycle after G+2. CPU write: CACK after G+1, RWE high for exactly one cycle.
- Maximum video throughput: one read per 4 cycles (IDLE, V_ACC, V_DAT, ACK).
- Worst-case CPU stall with continuous video traffic: CPU_MAXWAIT + 4 cycles to grant.
- WAIT_n rises in the same cycle CACK is high.

## Test plan
- Reset with CREQ=0, VREQ=0 → all outputs 0 except WAIT_n=1; state IDLE.
- VREQ pulse, VADDR=0x123, RAM word 0x123=0xA5 → RAD=0x123 at E1+, VACK and VDATA=0xA5 3 edges after request.
- CPU write CADDR=0x7FF, CDI=0x3C, then CPU read of 0x7FF → one RWE pulse with RDI=0x3C; read returns CDO=0x3C; WAIT_n low until each CACK; a held CREQ gives no second CACK.
- VREQ every 4 cycles, CREQ read held, CPU_MAXWAIT=6 → CPU granted when cwait reaches 6 (≤10 cycles after CREQ); video resumes afterwards; VOVR stays 0.
- Two VREQ pulses 1 cycle apart while a CPU access is in progress → VOVR=1, only the first address read, one VACK.
- RESET_n low during C_DAT of a CPU read → no CACK. After release with CREQ still high, a full read is served and CACK is seen.
